// File: rtl/pipeline_stall_ctrl.sv
// Hazard and stall controller for the five-stage RV32I pipeline.
// Produces PC / pipeline-register enables and bubble-insert flushes for
// load-use hazards, taken-branch squashes and multi-cycle data-memory
// accesses. A watchdog parks the FSM in ERR if memory never answers.
module pipeline_stall_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             mem_busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_MEM_WAIT = 2'd1;
  localparam logic [1:0] S_ERR      = 2'd2;

  logic [1:0]        state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              load_use;
  logic              run_cycle;   // cycle evaluated with normal hazard rules

  // Load-use: EX load writes a register the ID instruction actually reads (x0 never hazards)
  always_comb begin
    load_use = ex_is_load && (ex_rd != 5'd0) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                (id_use_rs2 && (id_rs2 == ex_rd)));
  end

  // Next-state / wait-counter logic; a MEM_WAIT cycle that completes behaves as RUN
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    run_cycle = 1'b0;
    case (state)
      S_RUN: begin
        if (mem_req && !mem_ready) begin
          state_nxt = S_MEM_WAIT;
          wait_nxt  = WAIT_W'(1);
        end else begin
          run_cycle = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        if (mem_ready || !mem_req) begin
          run_cycle = 1'b1;
          state_nxt = S_RUN;
          wait_nxt  = '0;
        end else if (wait_cnt >= WAIT_W'(MEM_TIMEOUT - 1)) begin
          // this stalled cycle is the MEM_TIMEOUT-th one
          state_nxt = S_ERR;
          wait_nxt  = WAIT_W'(MEM_TIMEOUT);
        end else begin
          wait_nxt  = wait_cnt + WAIT_W'(1);
        end
      end
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_RUN;
    endcase
  end

  // Enables / flushes: branch outranks load-use; flushes only ride with enable=1
  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_en    = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    if (!rst && run_cycle) begin
      pc_en     = 1'b1;
      if_id_en  = 1'b1;
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
      if (ex_branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  assign mem_busy    = (state == S_MEM_WAIT);
  assign timeout_err = (state == S_ERR);

  // FSM state and wait counter; reset abandons any pending access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Saturating count of cycles the PC was held
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             stall_cnt <= '0;
    else if (!pc_en && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule
